// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the packing FIFO.
package fifo_pkg;

  localparam int FIFO_DEPTH_DEF = 8;
  localparam int FIFO_WIDTH_DEF = 32;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

  // Big-endian lane for a byte pointer: the first byte lands in the top lane.
  function automatic int lane_idx(input int nb, input int bp);
    return nb - 1 - bp;
  endfunction

endpackage

// File: rtl/fifo_byte_packer.sv
// Byte-to-word packer: owns the byte pointer and staging word and decides
// when a word (packed, flushed or written whole) is handed to storage.
module fifo_byte_packer
  import fifo_pkg::*;
#(
  parameter int  WIDTH = FIFO_WIDTH_DEF,
  localparam int NB    = WIDTH / 8,
  localparam int BPW   = (NB > 1) ? clog2(NB) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             wr_en_i,
  input  logic             wr_byte_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             flush_i,
  output logic [BPW-1:0]   bp_o,
  output logic             commit_valid_o,
  output logic [WIDTH-1:0] commit_data_o,
  output logic             align_err_o
);

  localparam logic [BPW-1:0] BP_FINAL = BPW'(NB - 1);

  logic [BPW-1:0]   bp_q, bp_d;
  logic [WIDTH-1:0] stage_q, stage_d;
  logic [NB-1:0]    lane_hit;

  // One-hot lane select for the incoming byte at the current pointer.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign lane_hit[gi] = (lane_idx(NB, int'(bp_q)) == gi);
  end

  // Write is applied first, then a flush acts on the resulting staging word.
  always_comb begin
    stage_d        = stage_q;
    bp_d           = bp_q;
    commit_valid_o = 1'b0;
    commit_data_o  = '0;
    align_err_o    = 1'b0;
    if (wr_en_i) begin
      if (wr_byte_i) begin
        for (int i = 0; i < NB; i++) begin
          if (lane_hit[i]) stage_d[i*8 +: 8] = wr_data_i[7:0];
        end
        if (bp_q == BP_FINAL) begin
          commit_valid_o = 1'b1;
          commit_data_o  = stage_d;
          stage_d        = '0;
          bp_d           = '0;
        end else begin
          bp_d = bp_q + BPW'(1);
        end
      end else if (bp_q == '0) begin
        commit_valid_o = 1'b1;
        commit_data_o  = wr_data_i;
      end else begin
        // Whole word would straddle a half-packed word: drop it.
        align_err_o = 1'b1;
      end
    end
    if (flush_i && (bp_d != '0)) begin
      commit_valid_o = 1'b1;
      commit_data_o  = stage_d;
      stage_d        = '0;
      bp_d           = '0;
    end
  end

  // Pointer and staging registers; reset and clear empty the staging word.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      bp_q    <= '0;
      stage_q <= '0;
    end else begin
      bp_q    <= bp_d;
      stage_q <= stage_d;
    end
  end

  assign bp_o = bp_q;

endmodule

// File: rtl/fifo_packer.sv
// Word FIFO with big-endian byte packing on the write side and a
// show-ahead pop on the read side, plus count and sticky error flags.
module fifo_packer
  import fifo_pkg::*;
#(
  parameter int  DEPTH = FIFO_DEPTH_DEF,
  parameter int  WIDTH = FIFO_WIDTH_DEF,
  localparam int NB    = WIDTH / 8,
  localparam int AW    = clog2(DEPTH),
  localparam int BPW   = (NB > 1) ? clog2(NB) : 1
) (
  input  logic             CLK,
  input  logic             RST_FIFO_,
  input  logic             CLR,
  input  logic             WR_EN,
  input  logic             WR_BYTE,
  input  logic [WIDTH-1:0] WR_DATA,
  input  logic             FLUSH,
  input  logic             RD_EN,
  output logic [WIDTH-1:0] RD_DATA,
  output logic             FULL,
  output logic             EMPTY,
  output logic [AW:0]      COUNT,
  output logic [BPW-1:0]   BP,
  output logic             BP_EQ0,
  output logic             BP_LAST,
  output logic             OVF,
  output logic             UNF,
  output logic             ALIGN_ERR
);

  localparam logic [AW:0] COUNT_MAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             ovf_q, ovf_d, unf_q, unf_d, align_q, align_d;
  logic             commit_valid, align_evt;
  logic [WIDTH-1:0] commit_data;
  logic             full_w, empty_w, pop, push;

  fifo_byte_packer #(.WIDTH(WIDTH)) u_packer (
    .clk_i          (CLK),
    .rst_ni         (RST_FIFO_),
    .clr_i          (CLR),
    .wr_en_i        (WR_EN),
    .wr_byte_i      (WR_BYTE),
    .wr_data_i      (WR_DATA),
    .flush_i        (FLUSH),
    .bp_o           (BP),
    .commit_valid_o (commit_valid),
    .commit_data_o  (commit_data),
    .align_err_o    (align_evt)
  );

  assign full_w  = (count_q == COUNT_MAX);
  assign empty_w = (count_q == '0);
  assign pop     = RD_EN && !empty_w;
  // A pop in the same cycle frees the slot, so a commit into a full FIFO survives.
  assign push    = commit_valid && (!full_w || pop);

  // Pointer, count and sticky-flag next state.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    align_d = align_q | align_evt;
    if (pop)  rptr_d = rptr_q + AW'(1);
    if (push) wptr_d = wptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (pop && !push) count_d = count_q - (AW+1)'(1);
    if (commit_valid && full_w && !pop) ovf_d = 1'b1;
    if (RD_EN && empty_w)               unf_d = 1'b1;
  end

  // Control state; reset and clear take priority over all traffic.
  always_ff @(posedge CLK) begin
    if (!RST_FIFO_ || CLR) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      align_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      align_q <= align_d;
    end
  end

  // Storage write; contents need no reset since EMPTY masks the read port.
  always_ff @(posedge CLK) begin
    if (push && RST_FIFO_ && !CLR) mem_q[wptr_q] <= commit_data;
  end

  assign RD_DATA   = empty_w ? '0 : mem_q[rptr_q];
  assign FULL      = full_w;
  assign EMPTY     = empty_w;
  assign COUNT     = count_q;
  assign BP_EQ0    = (BP == '0);
  assign BP_LAST   = (BP == BPW'(NB - 1));
  assign OVF       = ovf_q;
  assign UNF       = unf_q;
  assign ALIGN_ERR = align_q;

endmodule
